// File: rtl/quota_bitstream_gen_if.sv
// Handshake bundle between the quota source, the bitstream generator and the
// stochastic compute array. QW must match the generator's derived quota width.
interface quota_bitstream_gen_if #(
    parameter int QW = 6
);
    logic          in_valid;
    logic [QW-1:0] in_quota;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic          out_last;
    logic          out_first;

    // Generator side
    modport slave (
        input  in_valid, in_quota, out_ready,
        output in_ready, out_valid, out_bit, out_last, out_first
    );

    // Quota source / bitstream consumer side
    modport master (
        output in_valid, in_quota, out_ready,
        input  in_ready, out_valid, out_bit, out_last, out_first
    );
endinterface

// File: rtl/quota_bitstream_gen.sv
// Serialises a quota (number of ones) into a BITSTREAM-beat stochastic
// bitstream. One active stream plus a one-deep pending slot lets consecutive
// quotas stream without bubbles. Every output comes straight from a register.
//
// state    | meaning
// S_IDLE   | no active stream, out_valid low
// S_STREAM | emitting beat r_k of quota r_qa
// r_pend   | pending quota r_qp held (orthogonal to state)
module quota_bitstream_gen #(
    parameter int BITSTREAM = 64,
    parameter int MODE      = 0,
    parameter int QW        = $clog2(BITSTREAM)
) (
    input  logic                 clk,
    input  logic                 rst,
    quota_bitstream_gen_if.slave bus
);

    if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bitstream
        $error("quota_bitstream_gen: BITSTREAM must be a power of two >= 2");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("quota_bitstream_gen: MODE must be 0 or 1");
    end

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    localparam logic [QW-1:0] LAST_K = QW'(BITSTREAM - 1);

    // Beat index reordering: identity (thermometer) or bit-reversed counter
    // (low-discrepancy). Both are permutations of 0..BITSTREAM-1, so either
    // yields exactly qa ones per stream.
    function automatic logic beat_bit(input logic [QW-1:0] k, input logic [QW-1:0] qa);
        logic [QW-1:0] idx;
        idx = k;
        if (MODE == 1) begin
            for (int i = 0; i < QW; i++) begin
                idx[i] = k[QW-1-i];
            end
        end
        return idx < qa;
    endfunction

    state_t        r_state;
    logic          r_pend;
    logic [QW-1:0] r_qa;
    logic [QW-1:0] r_qp;
    logic [QW-1:0] r_k;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_out_bit;
    logic          r_out_first;
    logic          r_out_last;

    logic          w_accept;
    logic          w_xfer;
    logic          w_at_last;
    state_t        w_state_nxt;
    logic          w_pend_nxt;
    logic [QW-1:0] w_qa_nxt;
    logic [QW-1:0] w_qp_nxt;
    logic [QW-1:0] w_k_nxt;
    logic          w_stream_nxt;

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_xfer    = r_out_valid & bus.out_ready;
    assign w_at_last = (r_k == LAST_K);

    // Next-state decision: output transfer first, then input accept, so an
    // accept on the final beat of a lone stream lands directly in qa.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_qa_nxt    = r_qa;
        w_qp_nxt    = r_qp;
        w_k_nxt     = r_k;

        if (w_xfer) begin
            if (!w_at_last) begin
                w_k_nxt = r_k + QW'(1);
            end else if (r_pend) begin
                w_qa_nxt   = r_qp;
                w_k_nxt    = '0;
                w_pend_nxt = 1'b0;
            end else begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
        end

        if (w_accept) begin
            if (r_state == S_IDLE || (w_xfer && w_at_last && !r_pend)) begin
                w_state_nxt = S_STREAM;
                w_qa_nxt    = bus.in_quota;
                w_k_nxt     = '0;
            end else begin
                w_qp_nxt   = bus.in_quota;
                w_pend_nxt = 1'b1;
            end
        end

        w_stream_nxt = (w_state_nxt == S_STREAM);
    end

    // State and registered outputs; outputs are precomputed from next state
    // so they hold steady whenever k and qa do (i.e. under backpressure).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend      <= 1'b0;
            r_qa        <= '0;
            r_qp        <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_qa        <= w_qa_nxt;
            r_qp        <= w_qp_nxt;
            r_k         <= w_k_nxt;
            r_in_ready  <= !w_pend_nxt;
            r_out_valid <= w_stream_nxt;
            r_out_bit   <= w_stream_nxt && beat_bit(w_k_nxt, w_qa_nxt);
            r_out_first <= w_stream_nxt && (w_k_nxt == '0);
            r_out_last  <= w_stream_nxt && (w_k_nxt == LAST_K);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_bit   = r_out_bit;
    assign bus.out_first = r_out_first;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_quota_bitstream_gen.sv
// Directed bench for quota_bitstream_gen: four instances cover BITSTREAM 8/64
// in both bit orderings. Inputs change and outputs are sampled at negedge.
module tb_quota_bitstream_gen;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    quota_bitstream_gen_if #(.QW(3)) if8a ();
    quota_bitstream_gen_if #(.QW(3)) if8b ();
    quota_bitstream_gen_if #(.QW(6)) if64a ();
    quota_bitstream_gen_if #(.QW(6)) if64b ();

    quota_bitstream_gen #(.BITSTREAM(8), .MODE(0)) u_d8m0 (
        .clk(clk), .rst(rst), .bus(if8a.slave));
    quota_bitstream_gen #(.BITSTREAM(8), .MODE(1)) u_d8m1 (
        .clk(clk), .rst(rst), .bus(if8b.slave));
    quota_bitstream_gen #(.BITSTREAM(64), .MODE(0)) u_d64m0 (
        .clk(clk), .rst(rst), .bus(if64a.slave));
    quota_bitstream_gen #(.BITSTREAM(64), .MODE(1)) u_d64m1 (
        .clk(clk), .rst(rst), .bus(if64b.slave));

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (if8a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_8a: got %b want 0", if8a.out_valid); end
        n_checks++; if (if8a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_8a: got %b want 1", if8a.in_ready); end
        n_checks++; if (if8a.out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_bit_8a: got %b want 0", if8a.out_bit); end
        n_checks++; if (if8a.out_first !== 1'b0) begin n_fail++; $display("FAIL reset_first_8a: got %b want 0", if8a.out_first); end
        n_checks++; if (if8a.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last_8a: got %b want 0", if8a.out_last); end
        n_checks++; if (if8b.out_valid !== 1'b0 || if8b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_8b: valid %b ready %b want 0 1", if8b.out_valid, if8b.in_ready); end
        n_checks++; if (if64a.out_valid !== 1'b0 || if64a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_64a: valid %b ready %b want 0 1", if64a.out_valid, if64a.in_ready); end
        n_checks++; if (if64b.out_valid !== 1'b0 || if64b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_64b: valid %b ready %b want 0 1", if64b.out_valid, if64b.in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // BITSTREAM=8, MODE 0, quota 5
    task automatic test_unary();
        logic [7:0] exp_bits;
        exp_bits = 8'b0001_1111;
        if8a.in_quota  = 3'd5;
        if8a.in_valid  = 1'b1;
        if8a.out_ready = 1'b1;
        n_checks++; if (if8a.out_valid !== 1'b0) begin n_fail++; $display("FAIL unary_pre_valid: got %b want 0", if8a.out_valid); end
        @(negedge clk);
        if8a.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (if8a.out_valid !== 1'b1) begin n_fail++; $display("FAIL unary_valid beat %0d: got %b want 1", i, if8a.out_valid); end
            n_checks++; if (if8a.out_bit !== exp_bits[i]) begin n_fail++; $display("FAIL unary_bit beat %0d: got %b want %b", i, if8a.out_bit, exp_bits[i]); end
            n_checks++; if (if8a.out_first !== (i == 0)) begin n_fail++; $display("FAIL unary_first beat %0d: got %b want %b", i, if8a.out_first, (i == 0)); end
            n_checks++; if (if8a.out_last !== (i == 7)) begin n_fail++; $display("FAIL unary_last beat %0d: got %b want %b", i, if8a.out_last, (i == 7)); end
            @(negedge clk);
        end
        n_checks++; if (if8a.out_valid !== 1'b0) begin n_fail++; $display("FAIL unary_post_valid: got %b want 0", if8a.out_valid); end
    endtask

    // BITSTREAM=8, MODE 1, quota 3: bitrev order 0,4,2,6,1,5,3,7
    task automatic test_bitrev();
        logic [7:0] exp_bits;
        int ones;
        exp_bits = 8'b0001_0101;
        ones = 0;
        if8b.in_quota  = 3'd3;
        if8b.in_valid  = 1'b1;
        if8b.out_ready = 1'b1;
        @(negedge clk);
        if8b.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (if8b.out_valid !== 1'b1) begin n_fail++; $display("FAIL bitrev_valid beat %0d: got %b want 1", i, if8b.out_valid); end
            n_checks++; if (if8b.out_bit !== exp_bits[i]) begin n_fail++; $display("FAIL bitrev_bit beat %0d: got %b want %b", i, if8b.out_bit, exp_bits[i]); end
            if (if8b.out_bit === 1'b1) ones++;
            @(negedge clk);
        end
        n_checks++; if (ones != 3) begin n_fail++; $display("FAIL bitrev_ones: got %0d want 3", ones); end
        n_checks++; if (if8b.out_valid !== 1'b0) begin n_fail++; $display("FAIL bitrev_post_valid: got %b want 0", if8b.out_valid); end
    endtask

    // BITSTREAM=8, MODE 0, quotas 2 then 6 with no gap
    task automatic test_back_to_back();
        logic [15:0] exp_bits;
        logic        exp_rdy;
        exp_bits = 16'h3F03;
        if8a.in_quota  = 3'd2;
        if8a.in_valid  = 1'b1;
        if8a.out_ready = 1'b1;
        n_checks++; if (if8a.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_start: got %b want 1", if8a.in_ready); end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp_rdy = (i == 0) || (i >= 8);
            n_checks++; if (if8a.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid beat %0d: got %b want 1", i, if8a.out_valid); end
            n_checks++; if (if8a.out_bit !== exp_bits[i]) begin n_fail++; $display("FAIL b2b_bit beat %0d: got %b want %b", i, if8a.out_bit, exp_bits[i]); end
            n_checks++; if (if8a.in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready beat %0d: got %b want %b", i, if8a.in_ready, exp_rdy); end
            n_checks++; if (if8a.out_first !== (i == 0 || i == 8)) begin n_fail++; $display("FAIL b2b_first beat %0d: got %b", i, if8a.out_first); end
            n_checks++; if (if8a.out_last !== (i == 7 || i == 15)) begin n_fail++; $display("FAIL b2b_last beat %0d: got %b", i, if8a.out_last); end
            if (i == 0) if8a.in_quota = 3'd6;
            if (i == 1) if8a.in_valid = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (if8a.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_post_valid: got %b want 0", if8a.out_valid); end
    endtask

    // BITSTREAM=8, MODE 0, quota 4 with out_ready pattern 1,0,0,1
    task automatic test_backpressure();
        logic [3:0] pat;
        logic [7:0] rec;
        int         nrec;
        logic       prev_stall, prev_bit, prev_last, prev_first;
        pat = 4'b1001;
        rec = '0;
        nrec = 0;
        prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0; prev_first = 1'b0;
        if8a.in_quota  = 3'd4;
        if8a.in_valid  = 1'b1;
        if8a.out_ready = 1'b0;
        @(negedge clk);
        if8a.in_valid = 1'b0;
        for (int c = 0; c < 64 && nrec < 8; c++) begin
            if8a.out_ready = pat[c % 4];
            if (prev_stall) begin
                n_checks++; if (if8a.out_valid !== 1'b1 || if8a.out_bit !== prev_bit || if8a.out_last !== prev_last || if8a.out_first !== prev_first) begin
                    n_fail++; $display("FAIL bp_stable cycle %0d: v/bit/last/first %b%b%b%b want 1%b%b%b", c, if8a.out_valid, if8a.out_bit, if8a.out_last, if8a.out_first, prev_bit, prev_last, prev_first);
                end
            end
            if (if8a.out_valid === 1'b1 && if8a.out_ready === 1'b1) begin
                rec[nrec] = if8a.out_bit;
                n_checks++; if (if8a.out_first !== (nrec == 0)) begin n_fail++; $display("FAIL bp_first xfer %0d: got %b", nrec, if8a.out_first); end
                n_checks++; if (if8a.out_last !== (nrec == 7)) begin n_fail++; $display("FAIL bp_last xfer %0d: got %b", nrec, if8a.out_last); end
                nrec++;
            end
            prev_stall = (if8a.out_valid === 1'b1) && !if8a.out_ready;
            prev_bit   = if8a.out_bit;
            prev_last  = if8a.out_last;
            prev_first = if8a.out_first;
            @(negedge clk);
        end
        if8a.out_ready = 1'b1;
        n_checks++; if (nrec != 8) begin n_fail++; $display("FAIL bp_timeout: transferred %0d beats want 8", nrec); end
        n_checks++; if (rec !== 8'b0000_1111) begin n_fail++; $display("FAIL bp_sequence: got %b want 00001111 (beat0 at lsb)", rec); end
        n_checks++; if (if8a.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_post_valid: got %b want 0", if8a.out_valid); end
    endtask

    // BITSTREAM=64, both modes driven with the same quota (0 or 63)
    task automatic test_edge_quotas(input int q);
        int   ones_a, ones_b;
        logic exp_bit;
        ones_a = 0;
        ones_b = 0;
        if64a.in_quota = 6'(q);  if64b.in_quota = 6'(q);
        if64a.in_valid = 1'b1;   if64b.in_valid = 1'b1;
        if64a.out_ready = 1'b1;  if64b.out_ready = 1'b1;
        @(negedge clk);
        if64a.in_valid = 1'b0;   if64b.in_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_bit = (q == 63) ? (i != 63) : 1'b0;
            n_checks++; if (if64a.out_valid !== 1'b1 || if64a.out_bit !== exp_bit) begin n_fail++; $display("FAIL edge_m0 q%0d beat %0d: valid %b bit %b want 1 %b", q, i, if64a.out_valid, if64a.out_bit, exp_bit); end
            n_checks++; if (if64b.out_valid !== 1'b1 || if64b.out_bit !== exp_bit) begin n_fail++; $display("FAIL edge_m1 q%0d beat %0d: valid %b bit %b want 1 %b", q, i, if64b.out_valid, if64b.out_bit, exp_bit); end
            if (i == 0 || i == 63) begin
                n_checks++; if (if64a.out_first !== (i == 0) || if64a.out_last !== (i == 63)) begin n_fail++; $display("FAIL edge_marks q%0d beat %0d: first %b last %b", q, i, if64a.out_first, if64a.out_last); end
            end
            if (if64a.out_bit === 1'b1) ones_a++;
            if (if64b.out_bit === 1'b1) ones_b++;
            @(negedge clk);
        end
        n_checks++; if (ones_a != q) begin n_fail++; $display("FAIL edge_ones_m0 q%0d: got %0d want %0d", q, ones_a, q); end
        n_checks++; if (ones_b != q) begin n_fail++; $display("FAIL edge_ones_m1 q%0d: got %0d want %0d", q, ones_b, q); end
        n_checks++; if (if64a.out_valid !== 1'b0 || if64b.out_valid !== 1'b0) begin n_fail++; $display("FAIL edge_post_valid q%0d: got %b %b want 0 0", q, if64a.out_valid, if64b.out_valid); end
    endtask

    // BITSTREAM=8, MODE 0: reset at beat 3 with quota 2 pending, then quota 7
    task automatic test_reset_midstream();
        logic [7:0] exp_bits;
        exp_bits = 8'b0111_1111;
        if8a.in_quota  = 3'd5;
        if8a.in_valid  = 1'b1;
        if8a.out_ready = 1'b1;
        @(negedge clk);
        if8a.in_quota = 3'd2;
        @(negedge clk);
        if8a.in_valid = 1'b0;
        n_checks++; if (if8a.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending: in_ready %b want 0", if8a.in_ready); end
        repeat (2) @(negedge clk);
        n_checks++; if (if8a.out_valid !== 1'b1 || if8a.out_bit !== 1'b1 || if8a.out_first !== 1'b0) begin n_fail++; $display("FAIL rstmid_beat3: valid %b bit %b first %b want 1 1 0", if8a.out_valid, if8a.out_bit, if8a.out_first); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (if8a.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", if8a.out_valid); end
        n_checks++; if (if8a.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", if8a.in_ready); end
        rst = 1'b0;
        if8a.in_quota = 3'd7;
        if8a.in_valid = 1'b1;
        @(negedge clk);
        if8a.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (if8a.out_valid !== 1'b1 || if8a.out_bit !== exp_bits[i]) begin n_fail++; $display("FAIL rstmid_restart beat %0d: valid %b bit %b want 1 %b", i, if8a.out_valid, if8a.out_bit, exp_bits[i]); end
            n_checks++; if (if8a.out_first !== (i == 0)) begin n_fail++; $display("FAIL rstmid_first beat %0d: got %b", i, if8a.out_first); end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (if8a.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped cycle %0d: out_valid %b want 0", i, if8a.out_valid); end
            @(negedge clk);
        end
    endtask

    initial begin
        if8a.in_valid = 1'b0;  if8a.in_quota = '0;  if8a.out_ready = 1'b0;
        if8b.in_valid = 1'b0;  if8b.in_quota = '0;  if8b.out_ready = 1'b0;
        if64a.in_valid = 1'b0; if64a.in_quota = '0; if64a.out_ready = 1'b0;
        if64b.in_valid = 1'b0; if64b.in_quota = '0; if64b.out_ready = 1'b0;
        rst = 1'b1;
        test_reset();
        test_unary();
        test_bitrev();
        test_back_to_back();
        test_backpressure();
        test_edge_quotas(0);
        test_edge_quotas(63);
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
